// File: rtl/byte_lsu_if.sv
// byte_lsu_if: core handshake plus byte-wide memory port for byte_lsu.
// ALIGN_CHECK_EN adds the ERR completion flag.
interface byte_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  START;
  logic                  LS;
  logic [1:0]            SIZE;
  logic                  SIGNED;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [31:0]           WD;
  logic [31:0]           RD;
  logic                  BUSY;
  logic                  DONE;
`ifdef ALIGN_CHECK_EN
  logic                  ERR;
`endif
  logic [ADDR_WIDTH-1:0] M_ADDR;
  logic                  M_WE;
  logic [7:0]            M_WD;
  logic [7:0]            M_RD;

  // LSU side
  modport slave (
    input  START, LS, SIZE, SIGNED, ADDR, WD, M_RD,
    output RD, BUSY, DONE, M_ADDR, M_WE, M_WD
`ifdef ALIGN_CHECK_EN
    , output ERR
`endif
  );

  // core + memory side
  modport master (
    output START, LS, SIZE, SIGNED, ADDR, WD, M_RD,
    input  RD, BUSY, DONE, M_ADDR, M_WE, M_WD
`ifdef ALIGN_CHECK_EN
    , input ERR
`endif
  );
endinterface

// File: rtl/byte_lsu.sv
// byte_lsu: multicycle load/store initiator towards a byte-wide memory.
// Each access is split into 1/2/4 single-byte transfers, little-endian,
// one per cycle; loads are reassembled and zero/sign-extended.
// Optional feature macro: ALIGN_CHECK_EN (misaligned half/word -> ERR, no transfer).
module byte_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4
) (
  input logic        clk,
  input logic        reset,
  byte_lsu_if.slave  bus
);
  localparam int DW = BYTE_SIZE * 8;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_k;
  logic [1:0]            r_last;   // N-1: 0 byte, 1 half, 3 word
  logic                  r_ls;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_maddr;  // last driven memory address
  logic [DW-1:0]         r_wd;
  logic [DW-1:0]         r_buf;
  logic [31:0]           r_rd;
  logic [ADDR_WIDTH-1:0] w_xaddr;
  logic [DW-1:0]         w_buf;
  logic [31:0]           w_ext;
  logic                  w_accept;
  logic                  w_misalign;
`ifdef ALIGN_CHECK_EN
  logic                  r_err;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.START;
  assign w_xaddr  = r_addr + ADDR_WIDTH'(r_k);   // wraps mod 2^ADDR_WIDTH
  assign bus.RD   = r_rd;

`ifdef ALIGN_CHECK_EN
  // reserved size 11 behaves as word, so SIZE[1] covers both
  assign w_misalign = ((bus.SIZE == 2'b01) && bus.ADDR[0]) ||
                      (bus.SIZE[1] && (bus.ADDR[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // buffer with the byte arriving this cycle merged in, then extended by size
  always_comb begin
    w_buf = r_buf;
    w_buf[8*r_k +: 8] = bus.M_RD;
    case (r_last)
      2'd0:    w_ext = {{24{r_signed & w_buf[7]}},  w_buf[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_buf[15]}}, w_buf[15:0]};
      default: w_ext = 32'(w_buf);
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state and memory/handshake outputs
  always_comb begin
    w_next     = r_state;
    bus.BUSY   = 1'b0;
    bus.DONE   = 1'b0;
    bus.M_WE   = 1'b0;
    bus.M_WD   = 8'h00;
    bus.M_ADDR = r_maddr;
`ifdef ALIGN_CHECK_EN
    bus.ERR    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.START) w_next = w_misalign ? S_DONE : S_XFER;
      end
      S_XFER: begin
        bus.BUSY   = 1'b1;
        bus.M_ADDR = w_xaddr;
        bus.M_WE   = r_ls;
        if (r_ls) bus.M_WD = r_wd[8*r_k +: 8];
        if (r_k == r_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.BUSY = 1'b1;
        bus.DONE = 1'b1;
`ifdef ALIGN_CHECK_EN
        bus.ERR  = r_err;
`endif
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // request latch, byte counter, load buffer and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k      <= '0;
      r_last   <= '0;
      r_ls     <= 1'b0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_maddr  <= '0;
      r_wd     <= '0;
      r_buf    <= '0;
      r_rd     <= '0;
`ifdef ALIGN_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_k      <= '0;
        r_ls     <= bus.LS;
        r_signed <= bus.SIGNED;
        r_addr   <= bus.ADDR;
        r_wd     <= DW'(bus.WD);
        case (bus.SIZE)
          2'b00:   r_last <= 2'd0;
          2'b01:   r_last <= 2'd1;
          default: r_last <= 2'd3;
        endcase
`ifdef ALIGN_CHECK_EN
        r_err    <= w_misalign;
`endif
      end
      if (r_state == S_XFER) begin
        r_k     <= r_k + 2'd1;
        r_maddr <= w_xaddr;
        if (!r_ls) begin
          r_buf <= w_buf;
          // result is registered on the last byte so it is valid in DONE
          if (r_k == r_last) r_rd <= w_ext;
        end
      end
    end
  end
endmodule

// File: tb/tb_byte_lsu.sv
// tb_byte_lsu: table-driven checks of byte_lsu against a byte memory model,
// with write and completion scoreboards, plus hand-written corner sequences.
module tb_byte_lsu;
  logic clk = 1'b0;
  logic reset;
  logic init_mem;
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;

`ifdef ALIGN_CHECK_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  always #5 clk = ~clk;

  byte_lsu_if #(.ADDR_WIDTH(32)) bus ();

  byte_lsu #(.ADDR_WIDTH(32), .BYTE_SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // byte memory: asynchronous read, write on clock edge
  logic [7:0] mem [0:255];
  assign bus.M_RD = mem[bus.M_ADDR[7:0]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (bus.M_WE === 1'b1) begin
      mem[bus.M_ADDR[7:0]] <= bus.M_WD;
    end
  end

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [31:0] rd; logic err; } done_t;
  typedef struct {
    logic ls; logic [1:0] size; logic sgn;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] rd;
    logic err; int lat;
  } vec_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  logic [31:0] model_rd;
  logic [31:0] model_maddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // write and completion monitor
  always @(negedge clk) begin
    if (bus.M_WE === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%h data=%h t=%0t", bus.M_ADDR, bus.M_WD, $time);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", bus.M_ADDR, w.a);
        chk("wr_data", {24'h0, bus.M_WD}, {24'h0, w.d});
      end
    end else if (bus.M_WE === 1'b0) begin
      chk("wd_idle", {24'h0, bus.M_WD}, 32'h0);
    end
    if (bus.DONE === 1'b1) begin
      dones++;
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done rd=%h t=%0t", bus.RD, $time);
      end else begin
        done_t e;
        e = done_q.pop_front();
        chk("rd", bus.RD, e.rd);
`ifdef ALIGN_CHECK_EN
        chk("err", {31'h0, bus.ERR}, {31'h0, e.err});
`endif
      end
    end
  end

  function automatic vec_t mk(input logic ls, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int lat);
    vec_t v;
    logic mis;
    v.ls = ls; v.size = size; v.sgn = sgn; v.addr = addr; v.wd = wd; v.rd = rd;
    v.lat = lat; v.err = 1'b0;
    mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    if (AC && mis) begin v.err = 1'b1; v.lat = 1; end
    return v;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  task automatic drive(input logic ls, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.START = 1'b1; bus.LS = ls; bus.SIZE = size; bus.SIGNED = sgn;
    bus.ADDR = addr; bus.WD = wd;
  endtask

  // wait for DONE with a cycle budget; returns cycle number (1 = first after accept)
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) break;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input vec_t v);
    int n, cyc;
    done_t e;
    n = nbytes(v.size);
    if (v.ls && !v.err)
      for (int k = 0; k < n; k++) wr_q.push_back('{a: v.addr + 32'(k), d: v.wd[8*k +: 8]});
    if (!v.ls && !v.err) model_rd = v.rd;
    e.rd = model_rd; e.err = v.err;
    done_q.push_back(e);
    drive(v.ls, v.size, v.sgn, v.addr, v.wd);
    @(posedge clk); #1;
    bus.START = 1'b0;
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'(v.lat));
    @(posedge clk); #1;
    if (!v.err) model_maddr = v.addr + 32'(n - 1);
    chk("busy_after", {31'h0, bus.BUSY}, 32'h0);
    chk("maddr_hold", bus.M_ADDR, model_maddr);
  endtask

  vec_t vecs[$];

  initial begin
    int cyc, d0;
    logic [7:0] m42;
    vecs.push_back(mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0,        5));
    vecs.push_back(mk(0, 2'b00, 1, 32'h21, 32'h0,        32'hFFFFFFBE, 2));
    vecs.push_back(mk(0, 2'b00, 0, 32'h21, 32'h0,        32'h000000BE, 2));
    vecs.push_back(mk(0, 2'b01, 1, 32'h22, 32'h0,        32'hFFFFDEAD, 3));
    vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0,        32'hDEADBEEF, 5));
    vecs.push_back(mk(1, 2'b01, 0, 32'h30, 32'h12345678, 32'h0,        3));
    vecs.push_back(mk(0, 2'b01, 0, 32'h30, 32'h0,        32'h00005678, 3));
    vecs.push_back(mk(1, 2'b00, 0, 32'h32, 32'h00000080, 32'h0,        2));
    vecs.push_back(mk(0, 2'b00, 1, 32'h32, 32'h0,        32'hFFFFFF80, 2));
    vecs.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0,        32'h0000DEAD, 3));
    vecs.push_back(mk(0, 2'b10, 0, 32'h21, 32'h0,        32'h81DEADBE, 5));
    vecs.push_back(mk(0, 2'b01, 1, 32'h21, 32'h0,        32'hFFFFADBE, 3));
    vecs.push_back(mk(0, 2'b11, 0, 32'h20, 32'h0,        32'hDEADBEEF, 5));
    vecs.push_back(mk(1, 2'b01, 0, 32'hFFFFFFFF, 32'h0000CAFE, 32'h0,  3));
    vecs.push_back(mk(0, 2'b01, 0, 32'hFFFFFFFF, 32'h0,  32'h0000CAFE, 3));
    vecs.push_back(mk(0, 2'b10, 1, 32'h30, 32'h0,        32'h96805678, 5));

    reset = 1'b1; init_mem = 1'b1;
    bus.START = 1'b0; bus.LS = 1'b0; bus.SIZE = 2'b00; bus.SIGNED = 1'b0;
    bus.ADDR = '0; bus.WD = '0;
    model_rd = '0; model_maddr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; init_mem = 1'b0;
    @(negedge clk);
    chk("rst_rd",    bus.RD, 32'h0);
    chk("rst_busy",  {31'h0, bus.BUSY}, 32'h0);
    chk("rst_done",  {31'h0, bus.DONE}, 32'h0);
    chk("rst_we",    {31'h0, bus.M_WE}, 32'h0);
    chk("rst_maddr", bus.M_ADDR, 32'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) run(vecs[i]);

    // START during cycle 2 and held through DONE: ignored, 4 writes, one DONE
    d0 = dones;
    for (int k = 0; k < 4; k++) wr_q.push_back('{a: 32'h50 + 32'(k), d: 8'(32'h01020304 >> (8*k))});
    done_q.push_back('{rd: model_rd, err: 1'b0});
    drive(1, 2'b10, 0, 32'h50, 32'h01020304);
    @(posedge clk); #1;
    bus.START = 1'b0;
    @(posedge clk); #1;
    drive(1, 2'b10, 0, 32'h60, 32'hFFFFFFFF);
    wait_done(cyc);
    chk("busy_start_lat", 32'(cyc + 1), 32'd5);
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_start_busy", {31'h0, bus.BUSY}, 32'h0);
    chk("busy_start_dones", 32'(dones - d0), 32'd1);
    chk("busy_start_mem60", {24'h0, mem[8'h60]}, {24'h0, 8'h60 ^ 8'hA5});
    @(posedge clk); #1;

    // reset after two bytes of a word store
    d0 = dones;
    m42 = mem[8'h42];
    wr_q.push_back('{a: 32'h40, d: 8'hDD});
    wr_q.push_back('{a: 32'h41, d: 8'hCC});
    drive(1, 2'b10, 0, 32'h40, 32'hAABBCCDD);
    @(posedge clk); #1;
    bus.START = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_rd = '0; model_maddr = '0;
    @(negedge clk);
    chk("mid_rst_busy",  {31'h0, bus.BUSY}, 32'h0);
    chk("mid_rst_we",    {31'h0, bus.M_WE}, 32'h0);
    chk("mid_rst_maddr", bus.M_ADDR, 32'h0);
    chk("mid_rst_rd",    bus.RD, 32'h0);
    repeat (6) @(negedge clk);
    chk("mid_rst_dones", 32'(dones - d0), 32'd0);
    chk("mid_rst_m40", {24'h0, mem[8'h40]}, 32'hDD);
    chk("mid_rst_m41", {24'h0, mem[8'h41]}, 32'hCC);
    chk("mid_rst_m42", {24'h0, mem[8'h42]}, {24'h0, m42});
    @(posedge clk); #1;

    // a load after the reset still works
    run(mk(0, 2'b10, 0, 32'h40, 32'h0, {mem[8'h43], m42, 8'hCC, 8'hDD}, 5));

    repeat (2) @(posedge clk);
    chk("wr_q_empty",   32'(wr_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
